alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation codes and the request/result bundle for the sequential ALU.
package alu_seq_pkg;
  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_LSW = 3'd4,
    OP_CLR = 3'd5,
    OP_EMK = 3'd6,
    OP_INC = 3'd7
  } op_e;
endpackage

interface alu_seq_if #(
  parameter int WIDTH = 8
);
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: one operation in flight, valid/ready on both sides,
// shifts either iterative (one bit per cycle) or barrel (single cycle).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BARREL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             left_q, left_d;

  // Shift by s with zero fill; returns {last bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_fn(input logic [WIDTH-1:0] v,
                                              input logic [SHW-1:0]   s,
                                              input logic             to_left);
    logic [WIDTH:0] ext;
    if (to_left) begin
      ext = {1'b0, v} << s;
      return {ext[WIDTH], ext[WIDTH-1:0]};
    end else begin
      ext = {v, 1'b0} >> s;
      return {ext[0], ext[WIDTH:1]};
    end
  endfunction

  // Single-cycle evaluation of every op; returns {C, V, result}.
  function automatic logic [WIDTH+1:0] arith_fn(input op_e              opc,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic        [WIDTH:0]   usum;
    logic signed [WIDTH:0]   ssum;
    logic        [WIDTH-1:0] mask;
    logic        [WIDTH:0]   sh;
    usum = '0;
    ssum = '0;
    mask = ~({WIDTH{1'b1}} << y[SHW-1:0]);
    sh   = '0;
    case (opc)
      OP_SLL, OP_SRL: begin
        sh = shift_fn(x, y[SHW-1:0], opc == OP_SLL);
        return {sh[WIDTH], 1'b0, sh[WIDTH-1:0]};
      end
      OP_ADD: begin
        usum = {1'b0, x} + {1'b0, y};
        ssum = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        return {usum[WIDTH], ssum[WIDTH] ^ ssum[WIDTH-1], usum[WIDTH-1:0]};
      end
      OP_SUB: begin
        // The extended difference goes negative exactly when a borrow occurs.
        usum = {1'b0, x} - {1'b0, y};
        ssum = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        return {~usum[WIDTH], ssum[WIDTH] ^ ssum[WIDTH-1], usum[WIDTH-1:0]};
      end
      OP_INC: begin
        usum = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
        ssum = $signed({x[WIDTH-1], x}) + $signed({{WIDTH{1'b0}}, 1'b1});
        return {usum[WIDTH], ssum[WIDTH] ^ ssum[WIDTH-1], usum[WIDTH-1:0]};
      end
      OP_LSW:  return {2'b00, y};
      OP_EMK:  return {2'b00, x & mask};
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic             c,
                                          input logic             v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Next-state, work register and result computation.
  always_comb begin
    logic [WIDTH+1:0] alu;
    logic [WIDTH:0]   sh;
    logic             is_shift;
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    left_d   = left_q;
    alu      = '0;
    sh       = '0;
    is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL);
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // A zero shift amount finishes like a barrel shift, keeping latency at shamt+1.
          if (is_shift && (BARREL == 0) && (bus.b[SHW-1:0] != '0)) begin
            work_d  = bus.a;
            cnt_d   = bus.b[SHW-1:0];
            left_d  = (bus.op == OP_SLL);
            state_d = S_SHIFT;
          end else begin
            alu      = arith_fn(bus.op, bus.a, bus.b);
            result_d = alu[WIDTH-1:0];
            flags_d  = mk_flags(alu[WIDTH-1:0], alu[WIDTH+1], alu[WIDTH]);
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sh     = shift_fn(work_q, SHW'(1), left_q);
        work_d = sh[WIDTH-1:0];
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = sh[WIDTH-1:0];
          flags_d  = mk_flags(sh[WIDTH-1:0], sh[WIDTH], 1'b0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset clears everything, dropping any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      work_q      <= '0;
      left_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      left_q      <= left_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one iterative and one barrel instance, WIDTH=8.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) b0 ();
  alu_seq_if #(.WIDTH(8)) b1 ();

  alu_seq #(.WIDTH(8), .BARREL(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  alu_seq #(.WIDTH(8), .BARREL(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    string      name;
  } vec_t;

  function automatic logic get_ov(input bit w);
    return w ? b1.out_valid : b0.out_valid;
  endfunction
  function automatic logic get_ir(input bit w);
    return w ? b1.in_ready : b0.in_ready;
  endfunction
  function automatic logic [7:0] get_res(input bit w);
    return w ? b1.result : b0.result;
  endfunction
  function automatic logic [3:0] get_fl(input bit w);
    return w ? b1.flags : b0.flags;
  endfunction

  task automatic drive(input bit w, input logic v, input op_e op,
                       input logic [7:0] a, input logic [7:0] b);
    if (w) begin
      b1.in_valid = v; b1.op = op; b1.a = a; b1.b = b;
    end else begin
      b0.in_valid = v; b0.op = op; b0.a = a; b0.b = b;
    end
  endtask

  task automatic set_ordy(input bit w, input logic r);
    if (w) b1.out_ready = r;
    else   b0.out_ready = r;
  endtask

  // Present one request, wait (bounded) for the result; lat counts edges from accept.
  task automatic issue(input bit w, input op_e op, input logic [7:0] a, input logic [7:0] b,
                       input string name, output logic [7:0] res, output logic [3:0] fl,
                       output int lat);
    @(negedge clk);
    checks++;
    if (get_ir(w) !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready got=%b want=1", name, get_ir(w));
    end
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, OP_CLR, 8'h00, 8'h00);
    lat = 1;
    while (get_ov(w) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (get_ov(w) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got out_valid=%b want=1", name, get_ov(w));
    end
    res = get_res(w);
    fl  = get_fl(w);
  endtask

  task automatic consume(input bit w);
    @(negedge clk);
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 1'b0, OP_CLR, 8'h00, 8'h00);
    drive(1, 1'b0, OP_CLR, 8'h00, 8'h00);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", b0.out_valid); end
    checks++; if (b0.result !== 8'h00) begin failures++; $display("FAIL rst_result got=%h want=00", b0.result); end
    checks++; if (b0.flags !== 4'h0) begin failures++; $display("FAIL rst_flags got=%b want=0000", b0.flags); end
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", b0.in_ready); end
    checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid_b1 got=%b want=0", b1.out_valid); end
    // Release and request in the same cycle: the first edge after release accepts.
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1'b1, OP_ADD, 8'h01, 8'h02);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_CLR, 8'h00, 8'h00);
    checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL first_accept_valid got=%b want=1", b0.out_valid); end
    checks++; if (b0.result !== 8'h03) begin failures++; $display("FAIL first_accept_result got=%h want=03", b0.result); end
    consume(0);
  endtask

  task automatic test_arith();
    vec_t       v[12];
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    v[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0110, 1, "add_wrap"};
    v[1]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1001, 1, "add_ovf"};
    v[2]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0011, 1, "sub_ovf"};
    v[3]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b1000, 1, "sub_borrow"};
    v[4]  = '{OP_INC, 8'h7F, 8'h00, 8'h80, 4'b1001, 1, "inc_ovf"};
    v[5]  = '{OP_INC, 8'hFF, 8'h00, 8'h00, 4'b0110, 1, "inc_carry"};
    v[6]  = '{OP_LSW, 8'h3C, 8'hA5, 8'hA5, 4'b1000, 1, "lsw"};
    v[7]  = '{OP_CLR, 8'h12, 8'h34, 8'h00, 4'b0100, 1, "clr"};
    v[8]  = '{OP_EMK, 8'hFF, 8'h05, 8'h1F, 4'b0000, 1, "emk5"};
    v[9]  = '{OP_EMK, 8'hFF, 8'h00, 8'h00, 4'b0100, 1, "emk0"};
    v[10] = '{OP_EMK, 8'hA5, 8'hFB, 8'h05, 4'b0000, 1, "emk_hi_b"};
    v[11] = '{OP_ADD, 8'h35, 8'h4A, 8'h7F, 4'b0000, 1, "add_plain"};
    foreach (v[i]) begin
      issue(0, v[i].op, v[i].a, v[i].b, v[i].name, res, fl, lat);
      checks++; if (res !== v[i].res) begin failures++; $display("FAIL %s_result got=%h want=%h", v[i].name, res, v[i].res); end
      checks++; if (fl !== v[i].fl) begin failures++; $display("FAIL %s_flags got=%b want=%b", v[i].name, fl, v[i].fl); end
      checks++; if (lat != v[i].lat) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", v[i].name, lat, v[i].lat); end
      consume(0);
      checks++; if (get_ov(0) !== 1'b0) begin failures++; $display("FAIL %s_consumed got=%b want=0", v[i].name, get_ov(0)); end
    end
  endtask

  // Same vectors through both instances; iterative latency is shamt+1, barrel is 1.
  task automatic test_shift();
    vec_t       v[6];
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    int         want_lat;
    v[0] = '{OP_SLL, 8'h81, 8'h03, 8'h08, 4'b0000, 4, "sll3"};
    v[1] = '{OP_SRL, 8'h81, 8'h01, 8'h40, 4'b0010, 2, "srl1"};
    v[2] = '{OP_SLL, 8'h81, 8'h00, 8'h81, 4'b1000, 1, "sll0"};
    v[3] = '{OP_SRL, 8'h80, 8'h07, 8'h01, 4'b0000, 8, "srl7"};
    v[4] = '{OP_SLL, 8'h03, 8'hF7, 8'h80, 4'b1010, 8, "sll7"};
    v[5] = '{OP_SRL, 8'hC3, 8'h02, 8'h30, 4'b0010, 3, "srl2"};
    for (int w = 0; w < 2; w++) begin
      foreach (v[i]) begin
        want_lat = (w == 1) ? 1 : v[i].lat;
        issue(w[0], v[i].op, v[i].a, v[i].b, v[i].name, res, fl, lat);
        checks++; if (res !== v[i].res) begin failures++; $display("FAIL %s_b%0d_result got=%h want=%h", v[i].name, w, res, v[i].res); end
        checks++; if (fl !== v[i].fl) begin failures++; $display("FAIL %s_b%0d_flags got=%b want=%b", v[i].name, w, fl, v[i].fl); end
        checks++; if (lat != want_lat) begin failures++; $display("FAIL %s_b%0d_latency got=%0d want=%0d", v[i].name, w, lat, want_lat); end
        consume(w[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    issue(0, OP_ADD, 8'h03, 8'h04, "bp", res, fl, lat);
    checks++; if (res !== 8'h07) begin failures++; $display("FAIL bp_result got=%h want=07", res); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(0, 1'b1, OP_CLR, 8'h00, 8'h00);
      @(posedge clk); #1;
      checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid_c%0d got=%b want=1", c, b0.out_valid); end
      checks++; if (b0.result !== 8'h07) begin failures++; $display("FAIL bp_hold_result_c%0d got=%h want=07", c, b0.result); end
      checks++; if (b0.flags !== 4'b0000) begin failures++; $display("FAIL bp_hold_flags_c%0d got=%b want=0000", c, b0.flags); end
      checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_c%0d got=%b want=0", c, b0.in_ready); end
    end
    @(negedge clk);
    drive(0, 1'b0, OP_CLR, 8'h00, 8'h00);
    consume(0);
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", b0.out_valid); end
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", b0.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_ignored_pulses got=%b want=0", b0.out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    int         seen;
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    @(negedge clk);
    drive(0, 1'b1, OP_SLL, 8'hFF, 8'h07);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_CLR, 8'h00, 8'h00);
    @(posedge clk); #1;
    checks++; if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_shift got in_ready=%b want=0", b0.in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", b0.out_valid); end
    checks++; if (b0.result !== 8'h00) begin failures++; $display("FAIL mid_rst_result got=%h want=00", b0.result); end
    checks++; if (b0.flags !== 4'h0) begin failures++; $display("FAIL mid_rst_flags got=%b want=0000", b0.flags); end
    checks++; if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b want=1", b0.in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (b0.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_result got=%0d valid cycles want=0", seen); end
    issue(0, OP_ADD, 8'h01, 8'h01, "post_rst", res, fl, lat);
    checks++; if (res !== 8'h02) begin failures++; $display("FAIL post_rst_result got=%h want=02", res); end
    consume(0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time=%0t", $time);
    $fatal(1);
  end
endmodule
